// File: rtl/sp_window_sampler.sv
// Window sampler for the signal-probability counter sum: measures sp_in increments over
// programmable windows and queues tagged results in a first-word-fall-through FIFO.
module sp_window_sampler #(
    parameter int SUM_W = 18,
    parameter int WIN_W = 16,
    parameter int DEPTH = 4,
    parameter int ID_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic [WIN_W-1:0] win_len,
    input  logic [SUM_W-1:0] sp_in,
    output logic             busy,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [SUM_W-1:0] rd_data,
    output logic [ID_W-1:0]  rd_win_id,
    output logic             overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE, MEAS} state_t;

    state_t             state_q, state_d;
    logic [SUM_W-1:0]   base_q;
    logic [WIN_W-1:0]   len_q, cnt_q, len_eff;
    logic [ID_W-1:0]    id_q;
    logic               stop_pend_q, overflow_q;

    logic [SUM_W-1:0]   data_mem [DEPTH];
    logic [ID_W-1:0]    id_mem   [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   count_q;
    logic [SUM_W-1:0]   hold_data_q;
    logic [ID_W-1:0]    hold_id_q;

    logic               capture, fifo_full, pop, push, stop_now;
    logic [SUM_W-1:0]   delta;

    always_comb begin
        len_eff   = (win_len == '0) ? WIN_W'(1) : win_len;
        capture   = (state_q == MEAS) && (cnt_q == '0);
        fifo_full = (count_q == CNT_W'(DEPTH));
        rd_valid  = (count_q != '0);
        pop       = rd_valid && rd_ready;
        // A full FIFO still accepts the capture when the head leaves on the same edge.
        push      = capture && (!fifo_full || pop);
        stop_now  = stop_pend_q || stop;
        delta     = sp_in - base_q;
        busy      = (state_q == MEAS);
        overflow  = overflow_q;
        rd_data   = rd_valid ? data_mem[rd_ptr_q] : hold_data_q;
        rd_win_id = rd_valid ? id_mem[rd_ptr_q]   : hold_id_q;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = MEAS;
            MEAS:    if (capture && stop_now) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q      <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            id_q        <= '0;
            stop_pend_q <= 1'b0;
            overflow_q  <= 1'b0;
        end else if (state_q == IDLE) begin
            if (start) begin
                base_q      <= sp_in;
                len_q       <= len_eff;
                cnt_q       <= len_eff - WIN_W'(1);
                overflow_q  <= 1'b0;
                stop_pend_q <= 1'b0;
            end
        end else if (capture) begin
            // The next window begins on this same edge, so there is no gap between windows.
            base_q <= sp_in;
            cnt_q  <= len_q - WIN_W'(1);
            id_q   <= id_q + 1'b1;
            if (stop_now) stop_pend_q <= 1'b0;
            if (fifo_full && !pop) overflow_q <= 1'b1;
        end else begin
            cnt_q <= cnt_q - WIN_W'(1);
            if (stop) stop_pend_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            hold_data_q <= '0;
            hold_id_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                id_mem[i]   <= '0;
            end
        end else begin
            if (push) begin
                data_mem[wr_ptr_q] <= delta;
                id_mem[wr_ptr_q]   <= id_q;
                wr_ptr_q           <= wr_ptr_q + 1'b1;
            end
            // The popped entry is kept so the outputs hold their last value once empty.
            if (pop) begin
                hold_data_q <= data_mem[rd_ptr_q];
                hold_id_q   <= id_mem[rd_ptr_q];
                rd_ptr_q    <= rd_ptr_q + 1'b1;
            end
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

endmodule

// File: tb/tb_sp_window_sampler.sv
// Randomized self-checking bench for sp_window_sampler against a window/queue reference model.
module tb_sp_window_sampler;

    localparam int SUM_W = 18;
    localparam int WIN_W = 16;
    localparam int DEPTH = 4;
    localparam int ID_W  = 8;

    logic             clk = 1'b0;
    logic             rst, start, stop, rd_ready;
    logic [WIN_W-1:0] win_len;
    logic [SUM_W-1:0] sp_in;
    logic             busy, rd_valid, overflow;
    logic [SUM_W-1:0] rd_data;
    logic [ID_W-1:0]  rd_win_id;

    sp_window_sampler #(.SUM_W(SUM_W), .WIN_W(WIN_W), .DEPTH(DEPTH), .ID_W(ID_W)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .win_len(win_len), .sp_in(sp_in),
        .busy(busy), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_win_id(rd_win_id), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [ID_W-1:0]  id;
        logic [SUM_W-1:0] d;
    } ent_t;

    // Reference model: a window is described by its base sample and the cycle of its capture edge.
    bit               m_busy, m_sp, m_ovf;
    logic [SUM_W-1:0] m_base;
    logic [ID_W-1:0]  m_id;
    int               m_len, m_next, cyc;
    ent_t             q[$];
    logic [SUM_W-1:0] sp_step;
    bit               rand_step;

    function automatic void model_reset();
        m_busy = 0; m_sp = 0; m_ovf = 0; m_base = '0; m_id = '0; m_len = 1; m_next = 0;
        q.delete();
    endfunction

    function automatic void model_edge();
        int   pre;
        bit   pop, cap;
        ent_t e;
        pre = q.size();
        pop = (pre > 0) && rd_ready;
        cap = 0;
        e   = '0;
        if (!m_busy) begin
            if (start) begin
                m_base = sp_in;
                m_len  = (win_len == '0) ? 1 : int'(win_len);
                m_next = cyc + m_len;
                m_ovf  = 0; m_busy = 1; m_sp = 0;
            end
        end else if (cyc == m_next) begin
            e.id = m_id; e.d = sp_in - m_base;
            cap = 1;
            m_base = sp_in; m_next = cyc + m_len; m_id = m_id + 1'b1;
            if (m_sp || stop) begin m_busy = 0; m_sp = 0; end
        end else if (stop) begin
            m_sp = 1;
        end
        if (pop) void'(q.pop_front());
        if (cap) begin
            if (pre < DEPTH || pop) q.push_back(e);
            else m_ovf = 1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        if (rand_step) sp_step = SUM_W'($urandom_range(0, 9));
        sp_in = sp_in + sp_step;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; start = 0; stop = 0; rd_ready = 0;
        model_reset();
        @(negedge clk);
        rst = 0;
    endtask

    task automatic finish_meas();
        int n;
        stop = 1; tick(); stop = 0;
        n = 0;
        while (busy && n < 40) begin tick(); n++; end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL finish_meas busy: got %b exp 0", busy); end
        rd_ready = 1;
        repeat (DEPTH + 1) tick();
    endtask

    task automatic test_reset();
        rst = 1; start = 0; stop = 0; rd_ready = 0; win_len = '0; sp_in = '0;
        sp_step = '0; rand_step = 0; cyc = 0;
        model_reset();
        #12;
        checks += 5;
        if (busy !== 1'b0)     begin errors++; $display("FAIL reset busy: got %b exp 0", busy); end
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset rd_valid: got %b exp 0", rd_valid); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL reset overflow: got %b exp 0", overflow); end
        if (rd_data !== '0)    begin errors++; $display("FAIL reset rd_data: got %0h exp 0", rd_data); end
        if (rd_win_id !== '0)  begin errors++; $display("FAIL reset rd_win_id: got %0d exp 0", rd_win_id); end
        @(negedge clk);
        rst = 0;
    endtask

    task automatic test_basic();
        win_len = 16'd10; sp_step = 18'd3; rand_step = 0; rd_ready = 1;
        start = 1; tick(); start = 0;
        for (int k = 1; k <= 25; k++) begin
            tick();
            checks += 3;
            if (busy !== m_busy) begin errors++; $display("FAIL basic busy: got %b exp %b", busy, m_busy); end
            if (rd_valid !== (q.size() != 0)) begin errors++; $display("FAIL basic rd_valid: got %b exp %b", rd_valid, q.size() != 0); end
            if (overflow !== m_ovf) begin errors++; $display("FAIL basic overflow: got %b exp %b", overflow, m_ovf); end
            if (k == 10 || k == 20) begin
                checks += 3;
                if (rd_valid !== 1'b1) begin errors++; $display("FAIL basic valid_at_%0d: got %b exp 1", k, rd_valid); end
                if (rd_data !== 18'd30) begin errors++; $display("FAIL basic data_at_%0d: got %0d exp 30", k, rd_data); end
                if (rd_win_id !== ID_W'(k / 10 - 1)) begin errors++; $display("FAIL basic id_at_%0d: got %0d exp %0d", k, rd_win_id, k / 10 - 1); end
            end
        end
        finish_meas();
    endtask

    task automatic test_wrap_minlen();
        sp_in = 18'h3FFF0; sp_step = 18'd8; win_len = 16'd4; rd_ready = 1;
        start = 1; tick(); start = 0;
        repeat (4) tick();
        checks += 2;
        if (rd_valid !== 1'b1) begin errors++; $display("FAIL wrap valid: got %b exp 1", rd_valid); end
        if (rd_data !== 18'h20) begin errors++; $display("FAIL wrap delta: got %0h exp 20", rd_data); end
        finish_meas();
        win_len = '0; rand_step = 1;
        start = 1; tick(); start = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            checks += 2;
            if (rd_valid !== 1'b1) begin errors++; $display("FAIL minlen valid_%0d: got %b exp 1", k, rd_valid); end
            if (q.size() != 0 && {rd_win_id, rd_data} !== q[0]) begin
                errors++; $display("FAIL minlen head_%0d: got id %0d data %0h exp id %0d data %0h", k, rd_win_id, rd_data, q[0].id, q[0].d);
            end
        end
        finish_meas();
        rand_step = 0;
    endtask

    task automatic test_stop();
        win_len = 16'd8; sp_step = 18'd1; rd_ready = 0;
        start = 1; tick(); start = 0;
        repeat (2) tick();
        stop = 1; tick(); stop = 0;
        repeat (4) tick();
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL stop_pulse busy_e7: got %b exp 1", busy); end
        tick();
        checks += 3;
        if (busy !== 1'b0) begin errors++; $display("FAIL stop_pulse busy_e8: got %b exp 0", busy); end
        if (rd_valid !== 1'b1) begin errors++; $display("FAIL stop_pulse valid: got %b exp 1", rd_valid); end
        if (rd_data !== 18'd8) begin errors++; $display("FAIL stop_pulse data: got %0d exp 8", rd_data); end
        repeat (3) tick();
        rd_ready = 1; tick();
        checks += 2;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL stop_pulse one_entry: got %b exp 0", rd_valid); end
        if (busy !== 1'b0) begin errors++; $display("FAIL stop_pulse stays_idle: got %b exp 0", busy); end
        rd_ready = 0;
        start = 1; tick(); start = 0;
        repeat (7) tick();
        stop = 1; tick(); stop = 0;
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL stop_edge busy_e8: got %b exp 0", busy); end
        if (rd_valid !== 1'b1) begin errors++; $display("FAIL stop_edge valid: got %b exp 1", rd_valid); end
        rd_ready = 1; tick();
        checks++;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL stop_edge one_entry: got %b exp 0", rd_valid); end
    endtask

    task automatic test_overflow();
        int got[$];
        int exp_ids[5] = '{0, 1, 2, 3, 6};
        do_reset();
        rand_step = 1; win_len = 16'd2; rd_ready = 0;
        start = 1; tick(); start = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            checks += 2;
            if (overflow !== m_ovf) begin errors++; $display("FAIL ovf model_%0d: got %b exp %b", k, overflow, m_ovf); end
            if (q.size() != 0 && {rd_win_id, rd_data} !== q[0]) begin
                errors++; $display("FAIL ovf head_%0d: got id %0d data %0h exp id %0d data %0h", k, rd_win_id, rd_data, q[0].id, q[0].d);
            end
            if (k == 9 || k == 10) begin
                checks++;
                if (overflow !== (k == 10)) begin errors++; $display("FAIL ovf flag_e%0d: got %b exp %b", k, overflow, k == 10); end
            end
        end
        stop = 1; rd_ready = 1;
        for (int k = 0; k < 8; k++) begin
            if (rd_valid) got.push_back(int'(rd_win_id));
            tick(); stop = 0;
        end
        checks++;
        if (got.size() != 5) begin errors++; $display("FAIL ovf drain_count: got %0d exp 5", got.size()); end
        for (int i = 0; i < 5 && i < got.size(); i++) begin
            checks++;
            if (got[i] != exp_ids[i]) begin errors++; $display("FAIL ovf drain_id_%0d: got %0d exp %0d", i, got[i], exp_ids[i]); end
        end
        rand_step = 0;
    endtask

    task automatic test_full_pop();
        int got[$];
        do_reset();
        win_len = 16'd2; rd_ready = 0; sp_step = 18'd5;
        start = 1; tick(); start = 0;
        repeat (9) tick();
        rd_ready = 1; tick(); rd_ready = 0;
        checks += 3;
        if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop overflow: got %b exp 0", overflow); end
        if (rd_win_id !== 8'd1) begin errors++; $display("FAIL fullpop head_id: got %0d exp 1", rd_win_id); end
        if (rd_data !== 18'd10) begin errors++; $display("FAIL fullpop head_data: got %0d exp 10", rd_data); end
        stop = 1; rd_ready = 1;
        for (int k = 0; k < 8; k++) begin
            if (rd_valid) got.push_back(int'(rd_win_id));
            tick(); stop = 0;
        end
        checks += 2;
        if (got.size() != 5) begin errors++; $display("FAIL fullpop drain_count: got %0d exp 5", got.size()); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL fullpop overflow_end: got %b exp 0", overflow); end
        for (int i = 0; i < got.size() && i < 5; i++) begin
            checks++;
            if (got[i] != i + 1) begin errors++; $display("FAIL fullpop drain_id_%0d: got %0d exp %0d", i, got[i], i + 1); end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        win_len = 16'd2; rd_ready = 0; sp_step = 18'd2;
        start = 1; tick(); start = 0;
        repeat (4) tick();
        checks++;
        if (rd_valid !== 1'b1) begin errors++; $display("FAIL rstmid queued: got %b exp 1", rd_valid); end
        #3;
        rst = 1;
        model_reset();
        #1;
        checks += 3;
        if (busy !== 1'b0)     begin errors++; $display("FAIL rstmid busy: got %b exp 0", busy); end
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL rstmid rd_valid: got %b exp 0", rd_valid); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL rstmid overflow: got %b exp 0", overflow); end
        #2;
        rst = 0;
        start = 1; tick(); start = 0;
        repeat (2) tick();
        checks += 2;
        if (rd_valid !== 1'b1) begin errors++; $display("FAIL rstmid restart_valid: got %b exp 1", rd_valid); end
        if (rd_win_id !== 8'd0) begin errors++; $display("FAIL rstmid restart_id: got %0d exp 0", rd_win_id); end
        finish_meas();
    endtask

    task automatic test_random();
        do_reset();
        rand_step = 1;
        for (int k = 0; k < 600; k++) begin
            start    = ($urandom_range(0, 3) == 0);
            stop     = ($urandom_range(0, 15) == 0);
            rd_ready = ($urandom_range(0, 2) != 0);
            win_len  = WIN_W'($urandom_range(0, 5));
            tick();
            checks += 3;
            if (busy !== m_busy) begin errors++; $display("FAIL random busy_%0d: got %b exp %b", k, busy, m_busy); end
            if (rd_valid !== (q.size() != 0)) begin errors++; $display("FAIL random rd_valid_%0d: got %b exp %b", k, rd_valid, q.size() != 0); end
            if (overflow !== m_ovf) begin errors++; $display("FAIL random overflow_%0d: got %b exp %b", k, overflow, m_ovf); end
            if (q.size() != 0) begin
                checks++;
                if ({rd_win_id, rd_data} !== q[0]) begin
                    errors++; $display("FAIL random head_%0d: got id %0d data %0h exp id %0d data %0h", k, rd_win_id, rd_data, q[0].id, q[0].d);
                end
            end
        end
        start = 0;
        finish_meas();
        rand_step = 0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap_minlen();
        test_stop();
        test_overflow();
        test_full_pop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
